reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_if.sv | 24 ++
 rtl/reg_file.sv | 47 ++++
 tb/tb_reg_file.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// The bench drives the master side; the register file sits on the slave side.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_we;
  logic [ADDR_W-1:0] i_waddr;
  logic [DATA_W-1:0] i_wdata;
  logic [ADDR_W-1:0] i_raddr1;
  logic [ADDR_W-1:0] i_raddr2;
  logic [DATA_W-1:0] o_rdata1;
  logic [DATA_W-1:0] o_rdata2;

  modport master (
    output i_we, i_waddr, i_wdata, i_raddr1, i_raddr2,
    input  o_rdata1, o_rdata2
  );

  modport slave (
    input  i_we, i_waddr, i_wdata, i_raddr1, i_raddr2,
    output o_rdata1, o_rdata2
  );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: 1 write port, 2 combinational read ports with write bypass.
// Writes land on the rising edge; reads have zero-cycle latency; register 0 reads as zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic      i_clk,
  input  logic      i_rst,
  reg_file_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;
  logic              byp1;
  logic              byp2;

  assign wr_en = bus.i_we && (bus.i_waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[bus.i_waddr] = bus.i_wdata;
    end
    regs_d[0] = '0;
  end

  // Reset has priority over a write on the same edge, so a pending write is discarded.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign byp1 = wr_en && (bus.i_waddr == bus.i_raddr1);
  assign byp2 = wr_en && (bus.i_waddr == bus.i_raddr2);

  assign bus.o_rdata1 = (i_rst || bus.i_raddr1 == '0) ? '0 :
                        byp1 ? bus.i_wdata : regs_q[bus.i_raddr1];
  assign bus.o_rdata2 = (i_rst || bus.i_raddr2 == '0) ? '0 :
                        byp2 ? bus.i_wdata : regs_q[bus.i_raddr2];
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: hand-computed vectors for write, read, bypass and reset behaviour.
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errs   = 0;

  reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a write, take one rising edge, then drop the enable.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.i_we    = 1'b1;
    bus.i_waddr = a;
    bus.i_wdata = d;
    @(posedge clk);
    #1;
    bus.i_we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.i_raddr1 = a1;
    bus.i_raddr2 = a2;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_we     = 1'b0;
    bus.i_waddr  = '0;
    bus.i_wdata  = '0;
    bus.i_raddr1 = '0;
    bus.i_raddr2 = '0;

    // Reset state: outputs forced to zero, bypass suppressed.
    bus.i_we    = 1'b1;
    bus.i_waddr = 5'd4;
    bus.i_wdata = 32'hCAFE_F00D;
    rd(5'd4, 5'd4);
    check("rst_byp1", bus.o_rdata1, 32'h0);
    check("rst_byp2", bus.o_rdata2, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    bus.i_we = 1'b0;
    rst      = 1'b0;
    rd(5'd4, 5'd31);
    check("rst_r4", bus.o_rdata1, 32'h0);
    check("rst_r31", bus.o_rdata2, 32'h0);

    // Write then read back.
    wr(5'd5, 32'h1234_5678);
    rd(5'd5, 5'd0);
    check("wr_rd_r5", bus.o_rdata1, 32'h1234_5678);

    // Register 0 ignores writes, including in the bypass window.
    bus.i_we    = 1'b1;
    bus.i_waddr = 5'd0;
    bus.i_wdata = 32'hFFFF_FFFF;
    rd(5'd0, 5'd0);
    check("r0_byp", bus.o_rdata1, 32'h0);
    @(posedge clk);
    #1;
    bus.i_we = 1'b0;
    rd(5'd5, 5'd0);
    check("r0_rd", bus.o_rdata2, 32'h0);

    // Dual read, different and identical addresses.
    wr(5'd3, 32'hA5A5_A5A5);
    wr(5'd7, 32'h5A5A_5A5A);
    rd(5'd3, 5'd7);
    check("dual_p1", bus.o_rdata1, 32'hA5A5_A5A5);
    check("dual_p2", bus.o_rdata2, 32'h5A5A_5A5A);
    rd(5'd3, 5'd3);
    check("same_p1", bus.o_rdata1, 32'hA5A5_A5A5);
    check("same_p2", bus.o_rdata2, 32'hA5A5_A5A5);

    // Bypass before the edge on port 1; port 2 on another address is unaffected.
    bus.i_we    = 1'b1;
    bus.i_waddr = 5'd9;
    bus.i_wdata = 32'hDEAD_BEEF;
    rd(5'd9, 5'd7);
    check("byp_p1", bus.o_rdata1, 32'hDEAD_BEEF);
    check("byp_other_p2", bus.o_rdata2, 32'h5A5A_5A5A);
    @(posedge clk);
    #1;
    bus.i_we = 1'b0;
    rd(5'd7, 5'd9);
    check("byp_commit", bus.o_rdata2, 32'hDEAD_BEEF);

    // Highest address.
    wr(5'd31, 32'h0BAD_CAFE);
    rd(5'd31, 5'd30);
    check("r31", bus.o_rdata1, 32'h0BAD_CAFE);
    check("r30", bus.o_rdata2, 32'h0);

    // Write disabled: nothing changes.
    bus.i_we    = 1'b0;
    bus.i_waddr = 5'd5;
    bus.i_wdata = 32'h0;
    @(posedge clk);
    #1;
    rd(5'd5, 5'd3);
    check("we0_r5", bus.o_rdata1, 32'h1234_5678);
    check("we0_r3", bus.o_rdata2, 32'hA5A5_A5A5);

    // Asynchronous reset pulse between clock edges.
    rst = 1'b1;
    #1;
    check("arst_r5", bus.o_rdata1, 32'h0);
    rst = 1'b0;
    #1;
    check("arst_after_r5", bus.o_rdata1, 32'h0);
    check("arst_after_r3", bus.o_rdata2, 32'h0);

    // Write on an edge during reset is discarded.
    rst         = 1'b1;
    bus.i_we    = 1'b1;
    bus.i_waddr = 5'd12;
    bus.i_wdata = 32'h7777_7777;
    rd(5'd12, 5'd12);
    check("rst_nobyp", bus.o_rdata2, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    bus.i_we = 1'b0;
    rd(5'd12, 5'd9);
    check("rst_wr_drop", bus.o_rdata1, 32'h0);
    check("rst_r9", bus.o_rdata2, 32'h0);

    // First write after reset is a normal write.
    wr(5'd12, 32'h1357_9BDF);
    rd(5'd12, 5'd0);
    check("post_rst_wr", bus.o_rdata1, 32'h1357_9BDF);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
